// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: request side (in_*, op_code, a, b)
// and result side (out_*, result, zero, carry). The controller uses master, the ALU uses slave.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;

  modport master (
    output in_valid, op_code, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry
  );

  modport slave (
    input  in_valid, op_code, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry
  );
endinterface

// File: rtl/alu_seq.sv
// Clocked ALU with registered result, zero/carry flags and a WIDTH-cycle shift-add multiply.
// Optional build macro ALU_SAT_EN: saturating ADD/SUB/MUL instead of wrap-around.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Each side
  // ignores its valid/ready partner while its own ready/valid is low.

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;

  logic               accept;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               in_ready_o;
  logic               out_valid_o;

  assign accept = bus.in_valid && in_ready_o;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (bus.op_code == 3'b111) ? S_MUL : S_DONE;
      S_MUL:  if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE:  in_ready_o  = 1'b1;
      S_DONE:  out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle operations, evaluated on the operands presented at accept.
  always_comb begin
    sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
    diff_ext  = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (bus.op_code)
      3'b000: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
`ifdef ALU_SAT_EN
        if (sum_ext[WIDTH]) alu_res = '1;
`endif
      end
      3'b001: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
`ifdef ALU_SAT_EN
        if (diff_ext[WIDTH]) alu_res = '0;
`endif
      end
      3'b010:  alu_res = bus.a & bus.b;
      3'b011:  alu_res = bus.a | bus.b;
      3'b100:  alu_res = bus.a ^ bus.b;
      3'b101:  alu_res = bus.a << bus.b[SHW-1:0];
      3'b110:  alu_res = bus.a >> bus.b[SHW-1:0];
      default: ;
    endcase
  end

  // Datapath: shift-add multiply consumes one multiplier bit per MUL cycle;
  // the last bit is folded in on the same edge that writes the result.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    mul_prod = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (state_q == S_IDLE && accept) begin
      if (bus.op_code == 3'b111) begin
        cnt_d    = CW'(WIDTH);
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, bus.a};
        mplier_d = bus.b;
      end else begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        carry_d  = alu_carry;
      end
    end else if (state_q == S_MUL) begin
      cnt_d    = cnt_q - CW'(1);
      acc_d    = mul_prod;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == CW'(1)) begin
        carry_d  = (mul_prod[2*WIDTH-1:WIDTH] != '0);
        result_d = mul_prod[WIDTH-1:0];
`ifdef ALU_SAT_EN
        if (carry_d) result_d = '1;
`endif
        zero_d   = (result_d == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.in_ready  = in_ready_o;
  assign bus.out_valid = out_valid_o;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8); expected values are hand-computed,
// with saturating variants selected by ALU_SAT_EN.
module tb_alu_seq;
  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: present one request, wait for accept, then count cycles to out_valid.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_code  = op;
    bus.a        = av;
    bus.b        = bv;
    check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_code  = 3'($urandom_range(0, 7));
    bus.a        = W'($urandom_range(0, 255));
    bus.b        = W'($urandom_range(0, 255));
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] er, input logic ez, input logic ec);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_result"}, {24'd0, bus.result}, {24'd0, er});
    check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, ez});
    check({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, ec});
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] er, input logic ez,
                        input logic ec, input int elat);
    int lat;
    issue(op, av, bv, lat);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check_out(tag, er, ez, ec);
    release_out(tag);
  endtask

  initial begin
    int lat;
    bit saw_valid;
    logic [W-1:0] held_res;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_code   = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_result", {24'd0, bus.result}, 32'd0);
    check("reset_flags", {30'd0, bus.zero, bus.carry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ALU_SAT_EN
    run_op("add_wrap", 3'b000, 8'hF0, 8'h20, 8'hFF, 1'b0, 1'b1, 1);
    run_op("sub_borrow", 3'b001, 8'h01, 8'h02, 8'h00, 1'b1, 1'b1, 1);
    run_op("mul_ovf", 3'b111, 8'd16, 8'd16, 8'hFF, 1'b0, 1'b1, 9);
    run_op("mul_ff", 3'b111, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 9);
`else
    run_op("add_wrap", 3'b000, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1);
    run_op("sub_borrow", 3'b001, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 1);
    run_op("mul_ovf", 3'b111, 8'd16, 8'd16, 8'h00, 1'b1, 1'b1, 9);
    run_op("mul_ff", 3'b111, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 9);
`endif
    run_op("add_small", 3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1);
    run_op("sub_zero", 3'b001, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0, 1);
    run_op("and", 3'b010, 8'h81, 8'h0B, 8'h01, 1'b0, 1'b0, 1);
    run_op("or", 3'b011, 8'h81, 8'h0B, 8'h8B, 1'b0, 1'b0, 1);
    run_op("xor", 3'b100, 8'h81, 8'hFF, 8'h7E, 1'b0, 1'b0, 1);
    run_op("shl", 3'b101, 8'h81, 8'h0B, 8'h08, 1'b0, 1'b0, 1);
    run_op("shr", 3'b110, 8'h81, 8'h0B, 8'h10, 1'b0, 1'b0, 1);
    run_op("mul_15x17", 3'b111, 8'd15, 8'd17, 8'hFF, 1'b0, 1'b0, 9);
    run_op("mul_13x11", 3'b111, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 9);

    // Backpressure: result held for 5 cycles while extra requests are ignored.
    issue(3'b011, 8'h30, 8'h03, lat);
    check("bp_latency", 32'(lat), 32'd1);
    check_out("bp_first", 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.op_code  = 3'b000;
      bus.a        = 8'hFF;
      bus.b        = 8'h01;
      @(posedge clk);
      #1;
      check("bp_hold_result", {24'd0, bus.result}, 32'h33);
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      check("bp_hold_flags", {30'd0, bus.zero, bus.carry}, 32'd0);
    end
    bus.in_valid = 1'b0;
    release_out("bp");
    held_res = bus.result;
    check("idle_keeps_result", {24'd0, held_res}, 32'h33);
    run_op("bp_next", 3'b100, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_code  = 3'b111;
    bus.a        = 8'd7;
    bus.b        = 8'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("mid_mul_busy", {31'd0, bus.in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid_result", {24'd0, bus.result}, 32'd0);
    check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_mid_flags", {30'd0, bus.zero, bus.carry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("no_stale_result", {31'd0, saw_valid}, 32'd0);
    check("post_rst_result", {24'd0, bus.result}, 32'd0);
    run_op("post_rst_add", 3'b000, 8'h22, 8'h11, 8'h33, 1'b0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the 3-bit-opcode combinational ALU: WIDTH-bit operands, registered result, zero/carry flags and an iterative multiply.
- Single operation in flight; valid/ready handshake on both input and output sides.
- Sits between an operand-issuing controller and a result consumer; replaces the combinational ALU where the datapath is pipelined.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount field width, taken from b[SHW-1:0] (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- op_code  input  3  operation select
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- carry  output  1  ADD carry-out / SUB borrow / MUL overflow; 0 otherwise

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1, out_valid=0, result=0, zero=0, carry=0; any multiply in progress is abandoned.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid && in_ready at a rising edge latches a, b and op_code.
  - op_code != 111: result/flags written on that edge; IDLE->DONE; out_valid high the next cycle (latency 1).
  - op_code == 111: IDLE->MUL; counter loaded with WIDTH.
- Op codes:
  - 000 ADD: a+b; carry = bit WIDTH of the sum.
  - 001 SUB: a-b; carry = borrow (a<b).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: a << b[SHW-1:0]; carry=0.
  - 110 SHR logical: a >> b[SHW-1:0]; carry=0.
  - 111 MUL: unsigned shift-add over a 2*WIDTH accumulator, one bit of b per cycle.
- MUL completion: after exactly WIDTH MUL cycles, result = low WIDTH bits; carry = (high WIDTH bits != 0); go to DONE. Total latency from accept to out_valid is WIDTH+1 cycles.
- zero is computed from the final WIDTH-bit result for every op.
- DONE: result and flags held stable while out_valid && !out_ready. out_ready=1 at an edge -> IDLE; in_ready rises the next cycle (no same-cycle back-to-back accept).
- Inputs a, b and op_code may change freely after accept; only the latched copies are used.
- in_valid is ignored while in_ready=0; out_ready is ignored while out_valid=0.
- Result and flags keep their last value in IDLE.
- Reset asserted mid-MUL or in DONE: immediate return to reset values; no result is produced.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: ADD clamps to all-ones on carry (carry still reports 1); SUB clamps to 0 on borrow (carry=1); MUL clamps to all-ones when the high half != 0.
- Undefined: wrap-around modulo 2^WIDTH as specified above.
- All other ops are identical in both builds.

Test Plan:
- Reset: WIDTH=8, rst_n=0 while mid-MUL -> out_valid=0, result=0, in_ready=1 immediately; after release, no stale result appears.
- ADD wrap: a=8'hF0, b=8'h20, op 000 -> one cycle later result=8'h10, carry=1, zero=0. With ALU_SAT_EN: result=8'hFF, carry=1.
- SUB zero: a=8'h55, b=8'h55, op 001 -> result=0, zero=1, carry=0. Then a=8'h01, b=8'h02 -> result=8'hFF, carry=1.
- Shifts/logic: a=8'h81, b=8'h0B, op 101 -> result=8'h08 (shift by b[2:0]=3). Op 110 -> 8'h10. Op 100 with b=8'hFF -> 8'h7E.
- MUL: a=8'd15, b=8'd17 -> out_valid exactly 9 cycles after accept, result=8'hFF, carry=0. a=8'd16, b=8'd16 -> result=8'h00, zero=1, carry=1 (8'hFF with ALU_SAT_EN).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, extra in_valid pulses ignored. Raise out_ready -> IDLE, and the next accept works.
